// File: rtl/lut_stream_reader.sv
// -----------------------------------------------------------------------------
// lut_stream_reader
//
// Avalon-MM read master that fetches a contiguous run of DATA_W-bit words
// from a fixed-latency, no-waitrequest on-chip memory slave and replays them
// as a single Avalon-ST packet with valid/ready backpressure.
//
// Reads are credit-limited: a read is only issued when the output FIFO is
// guaranteed to have room for it when it returns, so no word is ever dropped
// and the slave never needs to be stalled.
//
// Parameters
//   ADDR_W       memory word-address width (address wraps modulo 2^ADDR_W)
//   DATA_W       word width
//   READ_LATENCY cycles from read issue to valid mem_readdata (1..3)
//   FIFO_DEPTH   output buffer depth in words; keep >= READ_LATENCY+2 so a
//                fully-ready stream sees one beat per cycle without bubbles
//
// Ports
//   clk, reset          single clock, asynchronous active-high reset
//   start               one-cycle transfer request, sampled only in IDLE
//   base_addr, length   first word address and word count (0..2^ADDR_W)
//   busy                high while a transfer is in progress
//   done                one-cycle pulse at the end of a transfer
//   mem_*               Avalon-MM read master towards the memory slave
//   st_*                Avalon-ST source carrying the fetched words
// -----------------------------------------------------------------------------
module lut_stream_reader #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,

    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_clken,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_readdata,

    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_startofpacket,
    output logic                st_endofpacket
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Credit limit in the width of the credit sum, so the compare is exact.
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    // Transfer context, latched when a non-empty transfer is accepted.
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;      // reads issued so far
    logic [LEN_W-1:0]  beats;       // beats accepted downstream so far

    // Credit bookkeeping: every read is either in flight or sitting in the
    // FIFO until the stream accepts it.
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;

    // Return path: one valid bit per cycle of read latency.
    logic [READ_LATENCY-1:0] rd_pipe;

    // Output FIFO.
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic done_q;
    logic done_next;
    logic issue;
    logic push;
    logic pop;
    logic last_beat;
    logic start_xfer;

    // -------------------------------------------------------------------------
    // Static Avalon-MM qualifiers
    // -------------------------------------------------------------------------
    // The slave clock is enabled as soon as reset is released and stays on.
    assign mem_clken      = ~reset;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;

    // -------------------------------------------------------------------------
    // Derived handshake terms
    // -------------------------------------------------------------------------
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign push        = rd_pipe[READ_LATENCY-1];
    assign pop         = st_valid & st_ready;
    assign last_beat   = (beats == len_q - LEN_W'(1));
    assign start_xfer  = (state == S_IDLE) && start && (length != '0);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and read issue
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done_next  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_next = S_FETCH;
                    end else begin
                        // Empty transfer: acknowledge without touching memory.
                        done_next = 1'b1;
                    end
                end
            end

            S_FETCH: begin
                if (issued == len_q) begin
                    state_next = S_DRAIN;
                end else if (credit_used < DEPTH_L) begin
                    issue = 1'b1;
                end
            end

            S_DRAIN: begin
                // All reads are out; finish once the last beat is accepted.
                if (pop && last_beat) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Transfer context and progress counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            len_q  <= '0;
            issued <= '0;
            beats  <= '0;
        end else if (start_xfer) begin
            base_q <= base_addr;
            len_q  <= length;
            issued <= '0;
            beats  <= '0;
        end else begin
            if (issue) begin
                issued <= issued + LEN_W'(1);
            end
            if (pop) begin
                beats <= beats + LEN_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Return-path valid pipeline and credit counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pipe     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            done_q      <= 1'b0;
        end else begin
            rd_pipe[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(push);
            fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            done_q      <= done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the reset
    // pointers and count, and the head is masked until a word is present.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_readdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy           = (state != S_IDLE);
    assign done           = done_q;
    assign mem_chipselect = issue;
    assign mem_address    = issue ? (base_q + issued[ADDR_W-1:0]) : '0;

    // Packet markers come from the beat counter, which only advances on an
    // accepted beat, so they stay stable for as long as the sink stalls.
    assign st_valid         = (fifo_count != '0);
    assign st_data          = st_valid ? fifo_mem[rd_ptr] : '0;
    assign st_startofpacket = st_valid && (beats == '0);
    assign st_endofpacket   = st_valid && last_beat;

endmodule

// File: tb/tb_lut_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_lut_stream_reader
//
// Self-checking bench for lut_stream_reader. A behavioural slave returns
// mem[a] = a*3+1 with one cycle of latency. Each transfer is checked against
// the expected word sequence, packet markers, cycle timing and credit limit.
// -----------------------------------------------------------------------------
module tb_lut_stream_reader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int RL     = 1;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [1:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_readdata;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready = 1'b0;
    logic              st_startofpacket;
    logic              st_endofpacket;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lut_stream_reader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .READ_LATENCY(RL),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .base_addr       (base_addr),
        .length          (length),
        .busy            (busy),
        .done            (done),
        .mem_address     (mem_address),
        .mem_chipselect  (mem_chipselect),
        .mem_clken       (mem_clken),
        .mem_write       (mem_write),
        .mem_byteenable  (mem_byteenable),
        .mem_readdata    (mem_readdata),
        .st_data         (st_data),
        .st_valid        (st_valid),
        .st_ready        (st_ready),
        .st_startofpacket(st_startofpacket),
        .st_endofpacket  (st_endofpacket)
    );

    // Memory slave: registered address, data valid one cycle after the read.
    logic [ADDR_W-1:0] rd_addr_q = '0;
    always @(posedge clk) begin
        if (mem_clken) rd_addr_q <= mem_address;
    end
    assign mem_readdata = 16'(rd_addr_q) * 16'd3 + 16'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_word(input int a);
        return 16'(((a & 255) * 3) + 1);
    endfunction

    function automatic logic [31:0] reset_vec();
        return 32'({busy, done, mem_chipselect, mem_address, mem_clken,
                    st_valid, st_startofpacket, st_endofpacket, st_data});
    endfunction

    // One transfer. mode: 0 ready always high, 1 ready low in cycles 4-10,
    // 2 random ready, 3 ready high plus a stray start in cycle 3.
    // abort_at >= 0 asserts reset in that cycle and returns with reset held.
    // Entered and left just after a rising edge; cycle 0 is the start cycle.
    task automatic run_xfer(input int base, input int len, input int mode, input int abort_at);
        int nr, nb, n_done, done_cyc, first_v, last_cyc, in_flight, extra, budget;
        logic hold_pend;
        logic [17:0] hold_val;
        nr = 0; nb = 0; n_done = 0; done_cyc = -1; first_v = -1; last_cyc = -1;
        extra = 0; hold_pend = 1'b0; hold_val = '0;
        budget = len * 4 + 40;
        for (int c = 0; c < budget; c++) begin
            start     = (c == 0) || (mode == 3 && c == 3);
            base_addr = 8'((mode == 3 && c == 3) ? base + 64 : base);
            length    = 9'((mode == 3 && c == 3) ? 5 : len);
            case (mode)
                1:       st_ready = !(c >= 4 && c <= 10);
                2:       st_ready = ($urandom_range(3) != 0);
                default: st_ready = 1'b1;
            endcase
            if (c == abort_at) begin
                #2 reset = 1'b1;
                #1 check("reset_async", reset_vec(), 32'h0);
                start = 1'b0;
                return;
            end
            @(negedge clk);
            in_flight = nr - nb;
            if (done_cyc >= 0) begin
                if (mem_chipselect || st_valid || done) extra++;
            end else begin
                if (busy) check("credit_limit", 32'(in_flight <= DEPTH), 32'h1);
                if (in_flight == DEPTH) check("stall_cs", 32'(mem_chipselect), 32'h0);
                if (c == 1 && len > 0) check("busy_cs_c1", 32'({busy, mem_chipselect}), 32'h3);
                if (hold_pend)
                    check("hold", 32'({st_valid, st_data, st_startofpacket, st_endofpacket}),
                          32'({1'b1, hold_val}));
                if (mem_chipselect) begin
                    check("addr", 32'(mem_address), 32'((base + nr) & 255));
                    nr++;
                end
                if (st_valid && first_v < 0) first_v = c;
                hold_pend = st_valid && !st_ready;
                hold_val  = {st_data, st_startofpacket, st_endofpacket};
                if (st_valid && st_ready) begin
                    check("beat", 32'({st_data, st_startofpacket, st_endofpacket}),
                          32'({exp_word(base + nb), nb == 0, nb == len - 1}));
                    nb++;
                    last_cyc = c;
                end
                if (done) begin
                    n_done++;
                    done_cyc = c;
                    check("busy_at_done", 32'(busy), 32'h0);
                end
            end
            @(posedge clk); #1;
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        start = 1'b0;
        check("timeout", 32'(done_cyc >= 0), 32'h1);
        check("reads", 32'(nr), 32'(len));
        check("beats", 32'(nb), 32'(len));
        check("dones", 32'(n_done), 32'h1);
        check("quiet_after", 32'(extra), 32'h0);
        check("done_cyc", 32'(done_cyc), 32'((len == 0) ? 1 : last_cyc + 1));
        if (len > 0) check("first_valid", 32'(first_v), 32'(2 + RL));
        if (mode == 0 && len > 0) check("throughput", 32'(done_cyc), 32'(2 + RL + len));
    endtask

    initial begin
        #1 reset = 1'b1;
        #3 check("reset_vals", reset_vec(), 32'h0);
        check("mem_static", 32'({mem_write, mem_byteenable}), 32'h3);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        check("clken", 32'(mem_clken), 32'h1);

        run_xfer(8'h10, 4, 0, -1);      // basic
        run_xfer(8'hFE, 4, 0, -1);      // wrap
        run_xfer(8'h00, 16, 1, -1);     // backpressure
        run_xfer(8'h00, 0, 0, -1);      // empty
        run_xfer(8'h33, 1, 0, -1);      // single beat
        run_xfer(8'h80, 256, 0, -1);    // full space, last address 0x7F
        run_xfer(8'h20, 8, 3, -1);      // start while busy

        run_xfer(8'h00, 16, 0, 5);      // reset mid-transfer
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        run_xfer(8'h40, 2, 0, -1);

        for (int i = 0; i < 8; i++) begin
            run_xfer(int'($urandom_range(255)), int'($urandom_range(40)), 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
